// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// 8N1 UART receiver. The asynchronous rx line is synchronised, oversampled 16x,
// and each bit is decided by a majority vote of three mid-bit samples. The stop
// bit is checked, and each good byte is offered through a one-entry
// valid/ready holding register.
//
// Ports
//   clk25     in   core clock
//   rst_n     in   asynchronous active-low reset
//   rx        in   serial line, asynchronous, idle high
//   rx_data   out  [7:0] received byte, valid while rx_valid=1
//   rx_valid  out  holding register full
//   rx_ready  in   consumer accepts (transfer on rx_valid & rx_ready)
//   frame_err out  one-cycle pulse: stop bit sampled low
//   overrun   out  one-cycle pulse: byte completed while holding reg full
//   busy      out  receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_core #(
  parameter int CLK_HZ = 25175000,
  parameter int BAUD   = 115200,
  parameter int OVS    = 16
) (
  input  logic       clk25,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV_RAW = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [TW-1:0] TMAX    = TW'(DIV - 1);
  localparam logic [3:0]    OS_LAST = 4'(OVS - 1);
  localparam logic [3:0]    OS_S0   = 4'(OVS / 2 - 1);
  localparam logic [3:0]    OS_S1   = 4'(OVS / 2);
  localparam logic [3:0]    OS_S2   = 4'(OVS / 2 + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic          r_sync1;
  logic          r_rxs;
  logic          r_rxs_d;
  logic [TW-1:0] r_tcnt;
  logic [3:0]    r_os;
  logic [2:0]    r_bit_idx;
  logic          r_s0;
  logic          r_s1;
  logic [7:0]    r_shift;

  logic w_fall;
  logic w_tick;
  logic w_mid;
  logic w_end;
  logic w_maj;
  logic w_stop_mid;
  logic w_good;
  logic w_bad;
  logic w_take;

  function automatic logic f_maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Synchroniser: resets to the idle level so release never looks like a start
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
      r_rxs_d <= r_rxs;
    end
  end

  assign w_fall = r_rxs_d & ~r_rxs;
  assign w_tick = (r_state != S_IDLE) && (r_tcnt == TMAX);
  assign w_mid  = w_tick && (r_os == OS_S2);
  assign w_end  = w_tick && (r_os == OS_LAST);
  // Third vote is the live synchronised sample taken on the deciding tick
  assign w_maj  = f_maj(r_s0, r_s1, r_rxs);

  // Tick divider and oversample counter: parked at zero while idle so that a
  // start edge always begins a fresh bit period
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
      r_os   <= 4'd0;
    end else if (r_state == S_IDLE) begin
      r_tcnt <= '0;
      r_os   <= 4'd0;
    end else if (r_tcnt == TMAX) begin
      r_tcnt <= '0;
      r_os   <= r_os + 4'd1;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_idx <= 3'd0;
    end else if (r_state == S_START) begin
      r_bit_idx <= 3'd0;
    end else if ((r_state == S_DATA) && w_end) begin
      r_bit_idx <= r_bit_idx + 3'd1;
    end
  end

  // Sample / shift datapath: always overwritten before use, so no reset
  always_ff @(posedge clk25) begin
    if (w_tick && (r_os == OS_S0)) r_s0 <= r_rxs;
    if (w_tick && (r_os == OS_S1)) r_s1 <= r_rxs;
    if ((r_state == S_DATA) && w_mid) r_shift <= {w_maj, r_shift[7:1]};
  end

  // FSM state register
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_fall) w_state_nxt = S_START;
      S_START: begin
        if (w_mid && w_maj) w_state_nxt = S_IDLE;
        else if (w_end)     w_state_nxt = S_DATA;
      end
      S_DATA:  if (w_end && (r_bit_idx == 3'd7)) w_state_nxt = S_STOP;
      // Stop is decided at mid-bit so the next start edge is never missed
      S_STOP:  if (w_mid) w_state_nxt = w_maj ? S_IDLE : S_BREAK;
      S_BREAK: if (r_rxs) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (r_state != S_IDLE);
  end

  assign w_stop_mid = (r_state == S_STOP) && w_mid;
  assign w_good     = w_stop_mid & w_maj;
  assign w_bad      = w_stop_mid & ~w_maj;
  // A drain in the same cycle frees the slot for the new byte
  assign w_take     = w_good & (~rx_valid | rx_ready);

  // Holding register and status pulses
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= w_bad;
      overrun   <= w_good & rx_valid & ~rx_ready;
      if (w_take) begin
        rx_data  <= r_shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_core
// Directed bench for uart_rx_core at 16 clocks per bit. Frames are driven at
// the pin; for every frame the bench predicts, from frame timing alone, the
// clock edge at which the byte (or framing error) must appear, and a holding-
// register model tracks rx_valid / rx_data / frame_err / overrun each cycle.
// ---------------------------------------------------------------------------
module tb_uart_rx_core;

  logic       clk25 = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk25 = ~clk25;

  uart_rx_core #(
    .CLK_HZ(1600000),
    .BAUD  (100000)
  ) dut (
    .clk25    (clk25),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  // Pin-level start (first sampling edge) to rx_valid rising, in clocks:
  // 2 sync + 9 bit periods + 10 clocks into the stop bit.
  localparam int LAT = 2 + 16 * 9 + 10;

  typedef struct {
    int         at;
    logic       fe;
    logic [7:0] b;
  } ev_t;

  ev_t        evq[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         last_s = 0;
  int         rise_cnt = 0;
  int         rise_cyc = 0;
  logic [7:0] rise_data = 8'h00;
  int         fe_cnt = 0;
  int         ov_cnt = 0;

  logic       m_valid = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_fe = 1'b0;
  logic       m_ov = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  // Caller must be positioned at a negedge; returns at a negedge.
  task automatic send_frame(input logic [7:0] b, input logic stopv, input int inv_j);
    logic [9:0] bits;
    ev_t        e;
    bits   = {stopv, b, 1'b0};
    last_s = cyc + 1;
    e.at   = last_s + LAT;
    e.fe   = ~stopv;
    e.b    = b;
    evq.push_back(e);
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 16; j++) begin
        rx = bits[i] ^ (((i >= 1) && (i <= 8) && (j == inv_j)) ? 1'b1 : 1'b0);
        @(negedge clk25);
      end
    end
  endtask

  // Model update on the active edge, comparison on the opposite edge
  initial begin
    logic       ev_good;
    logic       ev_fe;
    logic [7:0] ev_b;
    logic       prev_v;
    prev_v = 1'b0;
    forever begin
      @(posedge clk25);
      cyc++;
      ev_good = 1'b0;
      ev_fe   = 1'b0;
      ev_b    = 8'h00;
      while ((evq.size() > 0) && (evq[0].at <= cyc)) begin
        if (evq[0].at == cyc) begin
          ev_good = ~evq[0].fe;
          ev_fe   = evq[0].fe;
          ev_b    = evq[0].b;
        end
        void'(evq.pop_front());
      end
      if (!rst_n) begin
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
        evq.delete();
      end else begin
        m_fe = ev_fe;
        m_ov = ev_good && m_valid && !rx_ready;
        if (ev_good && (!m_valid || rx_ready)) begin
          m_data  = ev_b;
          m_valid = 1'b1;
        end else if (m_valid && rx_ready) begin
          m_valid = 1'b0;
        end
      end

      @(negedge clk25);
      cmp("rx_valid", {31'd0, rx_valid}, {31'd0, m_valid});
      cmp("rx_data", {24'd0, rx_data}, {24'd0, m_data});
      cmp("frame_err", {31'd0, frame_err}, {31'd0, m_fe});
      cmp("overrun", {31'd0, overrun}, {31'd0, m_ov});
      if ((rx_valid === 1'b1) && !prev_v) begin
        rise_cnt++;
        rise_cyc  = cyc;
        rise_data = rx_data;
      end
      prev_v = (rx_valid === 1'b1);
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
    end
  end

  initial begin
    int r0;
    int f0;
    int o0;

    // Reset state
    repeat (3) @(negedge clk25);
    #1;
    cmp("rst_busy", {31'd0, busy}, 32'd0);
    cmp("rst_valid", {31'd0, rx_valid}, 32'd0);
    cmp("rst_data", {24'd0, rx_data}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk25);

    // 1: single byte, consumer ready
    rx_ready = 1'b1;
    r0 = rise_cnt;
    send_frame(8'hA5, 1'b1, -1);
    repeat (20) @(negedge clk25);
    #1;
    cmp("t1_latency", rise_cyc - last_s, 32'd156);
    cmp("t1_data", {24'd0, rise_data}, 32'hA5);
    cmp("t1_rises", rise_cnt - r0, 32'd1);
    cmp("t1_drained", {31'd0, rx_valid}, 32'd0);

    // 2: two bytes back-to-back with consumer stalled
    @(negedge clk25);
    rx_ready = 1'b0;
    o0 = ov_cnt;
    send_frame(8'h3C, 1'b1, -1);
    send_frame(8'h81, 1'b1, -1);
    repeat (20) @(negedge clk25);
    #1;
    cmp("t2_overruns", ov_cnt - o0, 32'd1);
    cmp("t2_held_valid", {31'd0, rx_valid}, 32'd1);
    cmp("t2_held_data", {24'd0, rx_data}, 32'h3C);
    @(negedge clk25);
    rx_ready = 1'b1;
    repeat (3) @(negedge clk25);
    #1;
    cmp("t2_drain", {31'd0, rx_valid}, 32'd0);

    // 3: 4-clock low glitch -> false start
    @(negedge clk25);
    r0 = rise_cnt;
    f0 = fe_cnt;
    repeat (4) begin
      rx = 1'b0;
      @(negedge clk25);
    end
    rx = 1'b1;
    #1;
    cmp("t3_busy_on", {31'd0, busy}, 32'd1);
    repeat (20) @(negedge clk25);
    #1;
    cmp("t3_busy_off", {31'd0, busy}, 32'd0);
    cmp("t3_no_valid", rise_cnt - r0, 32'd0);
    cmp("t3_no_ferr", fe_cnt - f0, 32'd0);

    // 4: framing error followed by a held-low line, then a good byte
    @(negedge clk25);
    r0 = rise_cnt;
    f0 = fe_cnt;
    send_frame(8'h55, 1'b0, -1);
    repeat (40) begin
      rx = 1'b0;
      @(negedge clk25);
    end
    rx = 1'b1;
    repeat (20) @(negedge clk25);
    #1;
    cmp("t4_ferr_once", fe_cnt - f0, 32'd1);
    cmp("t4_no_valid", rise_cnt - r0, 32'd0);
    cmp("t4_idle", {31'd0, busy}, 32'd0);
    @(negedge clk25);
    send_frame(8'h0F, 1'b1, -1);
    repeat (20) @(negedge clk25);
    #1;
    cmp("t4_next_data", {24'd0, rise_data}, 32'h0F);
    cmp("t4_next_rises", rise_cnt - r0, 32'd1);

    // 5: one-clock inversion on the middle vote of every data bit
    @(negedge clk25);
    send_frame(8'h96, 1'b1, 9);
    repeat (20) @(negedge clk25);
    #1;
    cmp("t5_vote", {24'd0, rise_data}, 32'h96);

    // 6: reset in the middle of a frame, then a clean byte
    @(negedge clk25);
    repeat (16) begin
      rx = 1'b0;
      @(negedge clk25);
    end
    repeat (48) begin
      rx = 1'b1;
      @(negedge clk25);
    end
    #1;
    cmp("t6_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk25);
    #1;
    cmp("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
    cmp("t6_rst_data", {24'd0, rx_data}, 32'd0);
    cmp("t6_rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk25);
    #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk25);
    r0 = rise_cnt;
    send_frame(8'h12, 1'b1, -1);
    repeat (20) @(negedge clk25);
    #1;
    cmp("t6_data", {24'd0, rise_data}, 32'h12);
    cmp("t6_rises", rise_cnt - r0, 32'd1);

    repeat (5) @(negedge clk25);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
